// File: rtl/gf233_sqrt_seq.sv
// Sequential multi-squaring unit for GF(2^233), f(x) = x^233 + x^74 + 1.
// Computes a^(2^k); sqrt_mode selects k = 232, which yields the field square root.

// Combinational squarer: spread a[i] onto x^(2i), then fold x^233 = x^74 + 1 from the top down.
module gf233_sqr (
    input  logic [232:0] a,
    output logic [232:0] y
);
    always_comb begin : fold
        logic [464:0] s;
        s = '0;
        for (int i = 0; i < 233; i++) begin
            s[2*i] = a[i];
        end
        // Descending order lets terms that land at or above x^233 get folded again.
        for (int j = 464; j >= 233; j--) begin
            s[j-233] = s[j-233] ^ s[j];
            s[j-159] = s[j-159] ^ s[j];
        end
        y = s[232:0];
    end
endmodule

// state  | meaning
// S_IDLE | waiting for start; d holds the last result
// S_RUN  | applying min(SQ_PER_CYCLE, cnt) squarings per cycle
// S_DONE | one-cycle done pulse, d valid
module gf233_sqrt_seq #(
    parameter int SQ_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sqrt_mode,
    input  logic [7:0]   k_in,
    input  logic [232:0] a,
    output logic [232:0] d,
    output logic         busy,
    output logic         done
);
    if (!(SQ_PER_CYCLE == 1 || SQ_PER_CYCLE == 2 || SQ_PER_CYCLE == 4 || SQ_PER_CYCLE == 8)) begin : g_bad_param
        $error("gf233_sqrt_seq: SQ_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] P_STEP = 8'(SQ_PER_CYCLE);

    state_t       state;
    logic [232:0] acc;
    logic [7:0]   cnt;
    logic [7:0]   k_eff;
    logic [7:0]   step;
    logic [232:0] acc_nxt;
    logic [232:0] tap [0:SQ_PER_CYCLE];

    assign k_eff = sqrt_mode ? 8'd232 : k_in;
    assign step  = (cnt < P_STEP) ? cnt : P_STEP;
    assign d     = acc;

    assign tap[0] = acc;
    for (genvar i = 0; i < SQ_PER_CYCLE; i++) begin : g_chain
        gf233_sqr u_sqr (
            .a(tap[i]),
            .y(tap[i+1])
        );
    end

    // Tap n of the chain holds acc^(2^n); the last step of a run may use fewer than SQ_PER_CYCLE.
    always_comb begin
        acc_nxt = tap[0];
        for (int i = 1; i <= SQ_PER_CYCLE; i++) begin
            if (step == 8'(i)) begin
                acc_nxt = tap[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc  <= a;
                        cnt  <= k_eff;
                        busy <= 1'b1;
                        if (k_eff == 8'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt - step;
                    if (cnt == step) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/gf233_sqrt_seq.md
# gf233_sqrt_seq

Sequential multi-squaring unit for GF(2^233) with reduction polynomial x^233 + x^74 + 1. It computes a^(2^k) for a programmable k. Its main use is the field square root, sqrt(a) = a^(2^232), which inverts the combinational squarer. It sits beside the squarer and multiplier in the field-arithmetic datapath and is driven by the point-arithmetic controller through a start/busy/done handshake.

## Interface
- SQ_PER_CYCLE, default 1: squarings applied per RUN cycle. Legal values are 1, 2, 4, 8. The datapath is a chain of this many combinational squarer stages.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Deasserted synchronously by the system.
- start  input  1  request pulse. Sampled only in IDLE.
- sqrt_mode  input  1  when 1, the effective count is 232 and k_in is ignored.
- k_in  input  8  number of squarings (0..255) when sqrt_mode=0.
- a  input  233  operand, polynomial basis, bit i is the coefficient of x^i.
- d  output  233  result register.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; d is valid while done is high.

## Operation
- States: IDLE, RUN, DONE.
- Registers: acc[232:0] (drives d), cnt[7:0].
- k = sqrt_mode ? 232 : k_in.
- IDLE with start=1: acc<=a, cnt<=k. Next state is DONE if k==0, otherwise RUN.
- IDLE with start=0: hold state.
- RUN on each edge:
  - n = min(SQ_PER_CYCLE, cnt).
  - acc <= acc squared n times, taken from tap n of the squarer chain.
  - cnt <= cnt - n.
  - If cnt == n, next state is DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- d holds acc at all times. It is stable from DONE until the next accepted start.
- start in RUN or DONE is ignored: no queueing, no effect on the current operation.
- Each squarer stage uses the field reduction by x^233 + x^74 + 1:
  - even output bits 2i take a[i] plus the folded high terms;
  - odd bits take a[117+...] terms;
  - e.g. x^117 squared = x^75 + x; x^116 squared = x^232.
- The squarer stage reuses the existing combinational squarer module, SQ_PER_CYCLE instances chained.
- Identity: a^(2^233) = a for every a.

## Timing
- Reset (rst_n=0, async): state=IDLE, acc=0, cnt=0, d=0, busy=0, done=0. Effective immediately, including mid-RUN; the operation is aborted and no done is produced.
- Start edge E: busy is high from E until the end of the done cycle.
- done rises after edge E + ceil(k/SQ_PER_CYCLE). For k=0, done is high in the cycle immediately after E.
- sqrt latency: 232 cycles at SQ_PER_CYCLE=1, 29 cycles at SQ_PER_CYCLE=8.
- Back-to-back: a start asserted in the cycle after done (state IDLE) is accepted. Minimum issue interval is ceil(k/P)+2 cycles.
- Critical path: SQ_PER_CYCLE XOR-squarer depths plus the tap mux. No combinational path from inputs to outputs.

## Test plan
- Reset mid-operation:
  - Stimulus: P=1, sqrt_mode=1, a=x^5; drop rst_n at cycle 100.
  - Response: d=0, busy=0 asynchronously; no done pulse.
  - Next start completes correctly.
- sqrt of x^2:
  - Stimulus: P=1, sqrt_mode=1, a=1<<2.
  - Response: done 232 cycles after the start edge; d=1<<1; busy low the cycle after done.
- Single squaring taps:
  - Stimulus: sqrt_mode=0, k_in=1, a=1<<117; then a=1<<116.
  - Response: d = (1<<75)|(1<<1); then d=1<<232.
- Frobenius identity across widths:
  - Stimulus: P=1 and P=8, k_in=233, a=random R.
  - Response: d=R; done after 233 and 30 edges respectively; covers the remainder path, 233 mod 8 = 1.
- k=0 and ignored start:
  - Stimulus: k_in=0, a=R gives done the next cycle with d=R. Then start an operation with k_in=10 and re-pulse start with different a/k at cycles 3 and 5.
  - Response: result equals R' squared 10 times; exactly one done.
- Random sqrt:
  - Stimulus: 1000 random a, sqrt_mode=1, P in {1,2,4,8}.
  - Response: the squarer model applied to d returns a every time; done width is exactly 1 cycle.
